// File: rtl/mem_ctrl_rr_pkg.sv
// mem_ctrl_rr shared definitions:
// size/direction codes, FSM states, load extension.
package mem_ctrl_rr_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic        flush;
    logic [31:0] wdata;
  } xact_t;

  function automatic logic [2:0] nbytes(
    input logic [1:0] sz
  );
    case (sz)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] ext_ld(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic        sgn
  );
    case (sz)
      SZ_B:    ext_ld = {{24{sgn & d[7]}}, d[7:0]};
      SZ_H:    ext_ld = {{16{sgn & d[15]}}, d[15:0]};
      default: ext_ld = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_if.sv
// mem_ctrl_rr requester bus:
// per-port request fields and completion.
interface mem_ctrl_rr_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_wr;
  logic [2*NUM_PORTS-1:0]      req_size;
  logic [NUM_PORTS-1:0]        req_signed;
  logic [NUM_PORTS-1:0]        req_flushable;
  logic [ADDR_W*NUM_PORTS-1:0] req_addr;
  logic [DATA_W*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        resp_done;
  logic [DATA_W-1:0]           resp_rdata;

  modport master (
    output req_valid, req_wr, req_size,
    output req_signed, req_flushable,
    output req_addr, req_wdata,
    input  resp_done, resp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_size,
    input  req_signed, req_flushable,
    input  req_addr, req_wdata,
    output resp_done, resp_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible
// port at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  localparam int PW = (NUM_PORTS > 1) ?
                      $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] elig,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!any && elig[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_rr.sv
// Multi-port byte-serial memory controller
// with round-robin grant, IO stall and flush.
module mem_ctrl_rr
  import mem_ctrl_rr_pkg::*;
#(
  parameter int         NUM_PORTS = 2,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [1:0] IO_SEL    = IO_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  mem_ctrl_rr_if.slave      bus
);

  localparam int PW = (NUM_PORTS > 1) ?
                      $clog2(NUM_PORTS) : 1;

  logic [1:0]          state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       l_port;
  logic [2:0]          k;
  logic [31:0]         cap;
  logic [ADDR_W-1:0]   l_addr;
  xact_t               l_x;

  logic                go, grant, win_any;
  logic                busy, last, stall;
  logic                abort, done;
  logic [NUM_PORTS-1:0] elig, win;
  logic [PW-1:0]       widx, nxt_ptr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [1:0]          w_size;
  logic                w_wr, w_sgn, w_flush;
  logic [2:0]          n;
  logic [1:0]          cb, ob;
  logic [31:0]         rd_full;

  assign go = rdy && !rst;

  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      elig[p] = bus.req_valid[p] &&
        !(bus.req_wr[p] && io_buffer_full &&
          bus.req_addr[p*ADDR_W+16 +: 2] == IO_SEL);
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .elig  (elig),
    .ptr   (rr_ptr),
    .grant (win),
    .any   (win_any)
  );

  always_comb begin
    widx = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (win[p]) widx = PW'(p);
  end

  assign w_addr  = bus.req_addr[widx*ADDR_W +: ADDR_W];
  assign w_wdata = bus.req_wdata[widx*DATA_W +: DATA_W];
  assign w_size  = bus.req_size[widx*2 +: 2];
  assign w_wr    = bus.req_wr[widx];
  assign w_sgn   = bus.req_signed[widx];
  assign w_flush = bus.req_flushable[widx];

  assign grant = go && !clr && win_any &&
                 state == ST_IDLE;

  assign n     = nbytes(l_x.size);
  assign busy  = state == ST_BUSY;
  assign last  = busy && k == n;
  assign stall = busy && !last && l_x.wr &&
                 l_addr[17:16] == IO_SEL &&
                 io_buffer_full;
  assign abort = go && busy && !l_x.wr &&
                 l_x.flush && clr;
  assign done  = go && last && !abort;

  assign cb = 2'(k - 3'd1);
  assign ob = 2'(k);

  // final byte arrives on mem_din in the done cycle
  always_comb begin
    rd_full = cap;
    rd_full[{cb, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    bus.resp_done = '0;
    if (done) bus.resp_done[l_port] = 1'b1;
  end

  assign bus.resp_rdata = (done && !l_x.wr) ?
    ext_ld(rd_full, l_x.size, l_x.sgn) : '0;

  assign nxt_ptr = (int'(l_port) == NUM_PORTS-1) ?
                   '0 : l_port + 1'b1;

  always_comb begin
    mem_addr = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    if (grant) begin
      mem_addr = w_addr;
      mem_wr   = w_wr;
      if (w_wr) mem_dout = w_wdata[7:0];
    end else if (busy && !last) begin
      mem_addr = l_addr + ADDR_W'(k);
      mem_wr   = go && l_x.wr && !stall;
      if (l_x.wr)
        mem_dout = l_x.wdata[{ob, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      k      <= '0;
      cap    <= '0;
      l_port <= '0;
      l_addr <= '0;
      l_x    <= '0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state  <= ST_BUSY;
            k      <= 3'd1;
            l_port <= widx;
            l_addr <= w_addr;
            l_x    <= '{wr:    w_wr,
                        size:  w_size,
                        sgn:   w_sgn,
                        flush: w_flush,
                        wdata: w_wdata};
          end
        end
        ST_BUSY: begin
          if (!l_x.wr)
            cap[{cb, 3'b000} +: 8] <= mem_din;
          if (abort || last) begin
            state  <= ST_GAP;
            k      <= '0;
            rr_ptr <= nxt_ptr;
          end else if (!stall) begin
            k <= k + 3'd1;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// Directed bench for mem_ctrl_rr: vector table
// plus hand sequences for stall/flush/freeze/reset.
module tb_mem_ctrl_rr;
  import mem_ctrl_rr_pkg::*;

  logic        clk, rst, rdy, clr, io_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_addr;
  logic        mem_wr;

  logic        bd_we;
  logic [17:0] bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  ram [0:262143];

  int checks = 0;
  int failures = 0;

  mem_ctrl_rr_if #(
    .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)
  ) bus ();

  mem_ctrl_rr #(
    .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clr            (clr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_addr       (mem_addr),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_full),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM holds mem_din while frozen
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (rdy) begin
      if (mem_wr) ram[mem_addr[17:0]] <= mem_dout;
      mem_din <= ram[mem_addr[17:0]];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    int          port;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic smp(); @(negedge clk); endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a,
                      input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    nxt();
    bd_we = 1'b0;
  endtask

  task automatic set_req(input int p,
                         input logic v, input logic wr,
                         input logic [1:0] sz,
                         input logic sg, input logic fl,
                         input logic [31:0] a,
                         input logic [31:0] d);
    bus.req_valid[p]          = v;
    bus.req_wr[p]             = wr;
    bus.req_size[2*p +: 2]    = sz;
    bus.req_signed[p]         = sg;
    bus.req_flushable[p]      = fl;
    bus.req_addr[32*p +: 32]  = a;
    bus.req_wdata[32*p +: 32] = d;
  endtask

  function automatic int bnum(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // drop the request in GAP and confirm the bus is idle
  task automatic fin(input int p);
    bus.req_valid[p] = 1'b0;
    smp();
    chk("gap_addr", mem_addr, 32'h0);
    chk("gap_wr", 32'(mem_wr), 32'h0);
    nxt();
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bit seen;
    logic [31:0] a;
    n = bnum(v.size);
    seen = 0;
    set_req(v.port, 1'b1, v.wr, v.size, v.sgn,
            1'b0, v.addr, v.wdata);
    for (int c = 0; c <= n + 3 && !seen; c++) begin
      smp();
      a = v.addr + 32'(c);
      if (c < n) begin
        chk("v_addr", mem_addr, a);
        chk("v_wr", 32'(mem_wr), 32'(v.wr));
        if (v.wr)
          chk("v_dout", 32'(mem_dout),
              (v.wdata >> (8*c)) & 32'hFF);
      end
      if (bus.resp_done != 2'b00) begin
        seen = 1;
        chk("v_done", 32'(bus.resp_done),
            32'(1 << v.port));
        chk("v_lat", c, n);
        chk("v_wr_done", 32'(mem_wr), 32'h0);
        if (!v.wr)
          chk("v_rdata", bus.resp_rdata, v.exp);
      end
      nxt();
      if (c == 0)
        set_req(v.port, 1'b1, ~v.wr, 2'd0, ~v.sgn,
                1'b1, 32'hDEAD_BEE0, ~v.wdata);
    end
    chk("v_seen", 32'(seen), 32'h1);
    fin(v.port);
  endtask

  task automatic wait_done(input int p, input int maxc,
                           input int lat,
                           input logic [31:0] a0,
                           input logic [31:0] rd);
    bit seen;
    seen = 0;
    for (int c = 0; c <= maxc && !seen; c++) begin
      smp();
      if (c == 0) chk("wd_addr0", mem_addr, a0);
      if (bus.resp_done != 2'b00) begin
        seen = 1;
        chk("wd_done", 32'(bus.resp_done), 32'(1 << p));
        chk("wd_lat", c, lat);
        chk("wd_rdata", bus.resp_rdata, rd);
      end
      nxt();
    end
    chk("wd_seen", 32'(seen), 32'h1);
    fin(p);
  endtask

  int nd;
  int dp [4];
  int dt [4];
  logic [31:0] drd [4];

  initial begin
    vt[0]  = '{1, 1'b0, SZ_W, 1'b0, 32'h100,
               32'h0, 32'h4433_2211};
    vt[1]  = '{0, 1'b0, SZ_H, 1'b1, 32'h200,
               32'h0, 32'hFFFF_FF80};
    vt[2]  = '{1, 1'b0, SZ_H, 1'b0, 32'h200,
               32'h0, 32'h0000_FF80};
    vt[3]  = '{0, 1'b0, SZ_B, 1'b1, 32'h200,
               32'h0, 32'hFFFF_FF80};
    vt[4]  = '{1, 1'b0, SZ_B, 1'b0, 32'h201,
               32'h0, 32'h0000_00FF};
    vt[5]  = '{0, 1'b1, SZ_W, 1'b0, 32'h300,
               32'hA1B2_C3D4, 32'h0};
    vt[6]  = '{1, 1'b0, SZ_W, 1'b0, 32'h300,
               32'h0, 32'hA1B2_C3D4};
    vt[7]  = '{0, 1'b0, SZ_W, 1'b0, 32'hFFFF_FFFF,
               32'h0, 32'h0302_015A};
    vt[8]  = '{1, 1'b1, SZ_H, 1'b0, 32'h401,
               32'h0000_BEEF, 32'h0};
    vt[9]  = '{0, 1'b0, SZ_H, 1'b1, 32'h401,
               32'h0, 32'hFFFF_BEEF};
    vt[10] = '{1, 1'b1, SZ_B, 1'b0, 32'h500,
               32'h1234_567F, 32'h0};
    vt[11] = '{0, 1'b0, SZ_B, 1'b1, 32'h500,
               32'h0, 32'h0000_007F};

    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    io_full = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.req_valid = '0; bus.req_wr = '0;
    bus.req_size = '0; bus.req_signed = '0;
    bus.req_flushable = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    nxt();
    poke(18'h00100, 8'h11); poke(18'h00101, 8'h22);
    poke(18'h00102, 8'h33); poke(18'h00103, 8'h44);
    poke(18'h00200, 8'h80); poke(18'h00201, 8'hFF);
    poke(18'h3FFFF, 8'h5A); poke(18'h00000, 8'h01);
    poke(18'h00001, 8'h02); poke(18'h00002, 8'h03);

    smp();
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wr", 32'(mem_wr), 32'h0);
    chk("rst_dout", 32'(mem_dout), 32'h0);
    chk("rst_done", 32'(bus.resp_done), 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    nxt();
    rst = 1'b0;
    smp();
    chk("idle_addr", mem_addr, 32'h0);
    nxt();

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // IO store blocked while the UART is full
    io_full = 1'b1;
    set_req(0, 1'b1, 1'b1, SZ_B, 1'b0, 1'b0,
            32'h0003_0000, 32'h41);
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("io_full_wr", 32'(mem_wr), 32'h0);
      chk("io_full_addr", mem_addr, 32'h0);
      chk("io_full_done", 32'(bus.resp_done), 32'h0);
      nxt();
    end
    io_full = 1'b0;
    smp();
    chk("io_wr", 32'(mem_wr), 32'h1);
    chk("io_addr", mem_addr, 32'h0003_0000);
    chk("io_dout", 32'(mem_dout), 32'h41);
    nxt();
    smp();
    chk("io_done", 32'(bus.resp_done), 32'h1);
    chk("io_wr_done", 32'(mem_wr), 32'h0);
    nxt();
    fin(0);

    // IO half store stalled mid-transfer
    set_req(0, 1'b1, 1'b1, SZ_H, 1'b0, 1'b0,
            32'h0003_0010, 32'h5152);
    smp();
    chk("ios_b0_wr", 32'(mem_wr), 32'h1);
    chk("ios_b0_dout", 32'(mem_dout), 32'h52);
    nxt();
    io_full = 1'b1;
    smp();
    chk("ios_stall_wr", 32'(mem_wr), 32'h0);
    chk("ios_stall_addr", mem_addr, 32'h0003_0011);
    chk("ios_stall_done", 32'(bus.resp_done), 32'h0);
    nxt();
    io_full = 1'b0;
    smp();
    chk("ios_b1_wr", 32'(mem_wr), 32'h1);
    chk("ios_b1_addr", mem_addr, 32'h0003_0011);
    chk("ios_b1_dout", 32'(mem_dout), 32'h51);
    nxt();
    smp();
    chk("ios_done", 32'(bus.resp_done), 32'h1);
    nxt();
    fin(0);

    // freeze two cycles mid-read on port 1
    set_req(1, 1'b1, 1'b0, SZ_W, 1'b0, 1'b0,
            32'h100, 32'h0);
    smp();
    chk("frz_addr0", mem_addr, 32'h100);
    nxt();
    smp();
    nxt();
    rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("frz_wr", 32'(mem_wr), 32'h0);
      chk("frz_done", 32'(bus.resp_done), 32'h0);
      nxt();
    end
    rdy = 1'b1;
    wait_done(1, 8, 2, 32'h102, 32'h4433_2211);

    // flushable read killed at offset 2, then regranted
    set_req(0, 1'b1, 1'b0, SZ_W, 1'b0, 1'b1,
            32'h100, 32'h0);
    smp();
    chk("fl_addr0", mem_addr, 32'h100);
    nxt();
    smp();
    nxt();
    clr = 1'b1;
    smp();
    chk("fl_done_clr", 32'(bus.resp_done), 32'h0);
    nxt();
    clr = 1'b0;
    smp();
    chk("fl_gap_addr", mem_addr, 32'h0);
    chk("fl_gap_done", 32'(bus.resp_done), 32'h0);
    nxt();
    wait_done(0, 8, 4, 32'h100, 32'h4433_2211);

    // stores are not aborted by clr
    set_req(0, 1'b1, 1'b1, SZ_W, 1'b0, 1'b1,
            32'h600, 32'h1122_3344);
    smp();
    chk("flw_b0", 32'(mem_dout), 32'h44);
    nxt();
    smp();
    nxt();
    clr = 1'b1;
    smp();
    chk("flw_b2_wr", 32'(mem_wr), 32'h1);
    chk("flw_b2_addr", mem_addr, 32'h602);
    chk("flw_b2_dout", 32'(mem_dout), 32'h22);
    nxt();
    clr = 1'b0;
    smp();
    chk("flw_b3_wr", 32'(mem_wr), 32'h1);
    chk("flw_b3_dout", 32'(mem_dout), 32'h11);
    nxt();
    smp();
    chk("flw_done", 32'(bus.resp_done), 32'h1);
    nxt();
    fin(0);

    // reset at offset 1 of a store
    set_req(0, 1'b1, 1'b1, SZ_W, 1'b0, 1'b0,
            32'h700, 32'hCAFE_F00D);
    smp();
    chk("rs_addr0", mem_addr, 32'h700);
    nxt();
    rst = 1'b1;
    bus.req_valid = '0;
    smp();
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      smp();
      chk("rs_addr", mem_addr, 32'h0);
      chk("rs_wr", 32'(mem_wr), 32'h0);
      chk("rs_dout", 32'(mem_dout), 32'h0);
      chk("rs_done", 32'(bus.resp_done), 32'h0);
      nxt();
    end

    // both ports competing: grants alternate from port 0
    set_req(0, 1'b1, 1'b0, SZ_W, 1'b0, 1'b0,
            32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, SZ_W, 1'b0, 1'b0,
            32'h100, 32'h0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      dp[i] = -1; dt[i] = -1; drd[i] = '0;
    end
    for (int c = 0; c < 40 && nd < 4; c++) begin
      smp();
      if (bus.resp_done != 2'b00) begin
        dp[nd]  = (bus.resp_done == 2'b01) ? 0 :
                  (bus.resp_done == 2'b10) ? 1 : 9;
        dt[nd]  = c;
        drd[nd] = bus.resp_rdata;
        nd++;
      end
      nxt();
    end
    bus.req_valid = '0;
    smp();
    nxt();
    nxt();
    chk("rr_count", nd, 4);
    chk("rr_first_lat", dt[0], 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_port", dp[i], i % 2);
      chk("rr_rdata", drd[i], 32'h4433_2211);
    end
    for (int i = 1; i < 4; i++)
      chk("rr_spacing", dt[i] - dt[i-1], 6);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_rr.md
Name: mem_ctrl_rr

Overview:
- Multi-port, byte-serial memory controller. Successor to the two-requester IF/LSB controller.
- Arbitrates NUM_PORTS requesters (IF, LSB, future D-cache/prefetch) onto the single 8-bit RAM/IO bus, round-robin.
- Serialises 1/2/4-byte loads and stores. Applies the UART-full back-pressure and the branch-flush abort.
- Returns sign- or zero-extended load data.

Parameters:
NUM_PORTS, 2, number of requester ports (port 0 highest initial RR priority)
ADDR_W, 32, address width (only [17:0] reach RAM)
DATA_W, 32, max access width; must be 32
IO_SEL, 2'b11, value of addr[17:16] selecting the IO region

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 = freeze
clr  in  1  flush (mispredict)
mem_din  in  8  RAM read byte, valid the cycle after its address
mem_dout  out  8  RAM write byte
mem_addr  out  ADDR_W  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full
req_valid  in  NUM_PORTS  request pending, per port
req_wr  in  NUM_PORTS  1 = store
req_size  in  2*NUM_PORTS  0 = byte, 1 = half, 2 = word
req_signed  in  NUM_PORTS  sign-extend load result
req_flushable  in  NUM_PORTS  read may be killed by clr
req_addr  in  ADDR_W*NUM_PORTS  byte address
req_wdata  in  DATA_W*NUM_PORTS  store data (low bytes used)
resp_done  out  NUM_PORTS  one-cycle completion pulse, one-hot
resp_rdata  out  DATA_W  load result, valid with resp_done

Behaviour:
- Reset: state IDLE, rr_ptr = 0, byte counter = 0, capture reg = 0. Outputs: resp_done = 0, resp_rdata = 0, mem_wr = 0, mem_addr = 0, mem_dout = 0.
- States:
  - IDLE: grant/issue byte 0.
  - BUSY: counter k = 1..n.
  - GAP: one dead cycle, mem_wr = 0, addr 0.
  - n = 1, 2 or 4 from the latched size.
- Eligibility: port p is eligible when req_valid[p] && !(req_wr[p] && req_addr[p][17:16] == IO_SEL && io_buffer_full).
- Grant: in IDLE with rdy && !clr, choose the first eligible port from rr_ptr upward, with wrap. No eligible port means stay in IDLE.
- Combinational grant: in the grant cycle, byte 0 drives mem_addr/mem_wr/mem_dout directly from the winner's inputs.
- Latching at grant: port, wr, size, signed, flushable, addr, wdata are registered. The requester may change its inputs after the grant cycle, but must keep req_valid high until resp_done.
- Read, n bytes: address a+k is presented in the cycle at offset k (k = 0..n-1). Byte k is captured in the cycle at offset k+1.
  - At offset n: resp_done[port] = 1.
  - resp_rdata = captured bytes, extended from bit 8n-1 if signed, else zero-extended.
  - Then GAP, then IDLE. Latency: grant to done = n cycles; next grant no earlier than n+2.
- Write, n bytes: byte k of wdata goes to a+k with mem_wr = 1 at offset k. At offset n: mem_wr = 0, resp_done pulses, then GAP.
- IO stall: for a latched IO-region write, any cycle with io_buffer_full = 1 has mem_wr = 0 and the counter held. The byte is reissued when full drops. Done is delayed by the stall count.
- Flush: clr = 1 during BUSY of a read with flushable = 1 aborts it. No resp_done, go to GAP.
  - Non-flushable reads are not aborted.
  - Writes are never aborted.
  - No grant in any cycle with clr = 1.
- rdy = 0 freezes all registers, including outputs; mem_wr is forced to 0. The RAM is required to hold mem_din over frozen cycles.
- rr_ptr = (granted port + 1) mod NUM_PORTS, updated on completion or abort.
- Address increment: 32-bit, wraps at 2^ADDR_W. Misaligned accesses are allowed.
- Simultaneous events:
  - resp_done and a new request on the same port: the new request waits at least through GAP.
  - rst overrides everything, including mid-transaction. The in-flight write is truncated with no done.
- In IDLE with no grant, and in GAP: mem_addr = 0, mem_wr = 0, mem_dout = 0.

Decomposition:
- Shared definitions file: size encodings (SZ_B/SZ_H/SZ_W), MEM_READ/MEM_WRITE, IO_SEL default, state encodings.
- One sub-module, rr_arbiter (NUM_PORTS): combinational first-eligible search from rr_ptr, with a one-hot grant output.
- The serialiser, extension logic and FSM stay in mem_ctrl_rr.

Test Plan:
- Word read: port 1 word read at 0x100, RAM bytes 11 22 33 44 → mem_addr 0x100..0x103 on consecutive cycles; resp_done[1] 4 cycles after grant; resp_rdata = 0x44332211.
- Signed half load: load at 0x200 with bytes 0x80 0xFF, signed → 0xFFFFFF80; same with req_signed = 0 → 0x0000FF80.
- Round-robin fairness: ports 0 and 1 both valid continuously (word reads) → grants alternate 0,1,0,1; each done separated by 6 cycles.
- IO stall: byte store 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles then 0 → no grant or mem_wr while full; then a single mem_wr = 1 cycle with dout 0x41; done next cycle.
- Flush: clr at offset 2 of a flushable word read → no resp_done, GAP, IDLE. Same on a word store → all 4 bytes written, done pulses.
- Freeze and reset: rdy = 0 for 2 cycles mid-read → result correct, done delayed by 2. rst at offset 1 of a word store → outputs 0 next cycle, rr_ptr = 0, no done.
